imem_loadable: RTL
==================

IMEM_LOADABLE -- requirements
Module: imem_loadable

Interface
- REQ-001: Parameters SHALL be (name, default, meaning):
  - DATA_W, 32, instruction word width.
  - DEPTH, 512, number of words.
  - ADDR_W, 32, byte-address width.
  - RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- REQ-002: clk, input, 1, single clock; all state updates on its rising edge.
- REQ-003: reset_n, input, 1; reset is asynchronous and active-low.
- REQ-004: rd_req, input, 1, read request.
- REQ-005: rd_addr, input, ADDR_W, byte address of the read.
- REQ-006: rd_valid, output, 1, read response valid.
- REQ-007: rd_data, output, DATA_W, read response word.
- REQ-008: rd_fault, output, 1, read response is a fault; qualified by rd_valid.
- REQ-009: ld_start, input, 1, begin or restart program load.
- REQ-010: ld_valid, input, 1, load word present.
- REQ-011: ld_data, input, DATA_W, load word.
- REQ-012: ld_last, input, 1, final load word; qualified by ld_valid.
- REQ-013: ld_ready, output, 1, loader accepts a word this cycle.
- REQ-014: ld_done, output, 1, one-cycle pulse when a load completes.
- REQ-015: ready, output, 1, memory holds a complete program.

Function
- REQ-016: FSM SHALL have states EMPTY, LOAD and READY.
  - reset_n low -> EMPTY.
  - EMPTY/READY + ld_start -> LOAD.
  - LOAD -> READY on the accepted word that has ld_last=1 or is written to index DEPTH-1.
- REQ-017: ld_ready SHALL be 1 exactly in LOAD, except in the cycle ld_start is sampled.
- REQ-018: Entering LOAD SHALL clear the write pointer to 0.
  - Each cycle with ld_valid & ld_ready writes ld_data to mem[ptr] and increments ptr.
- REQ-019: ld_start in LOAD SHALL restart the load (ptr=0); a word presented in the same cycle is discarded.
- REQ-020: ld_done SHALL pulse high for exactly one cycle, the cycle after the final word is written; ready rises in the same cycle.
- REQ-021: ready SHALL equal (state==READY); it drops the cycle after ld_start is sampled.
- REQ-022: A read SHALL be accepted every cycle rd_req=1 (no backpressure, fully pipelined).
  - rd_valid asserts exactly RD_LAT cycles after acceptance, for one cycle per request.
- REQ-023: Word index SHALL be rd_addr[ADDR_W-1:2].
- REQ-024: A read SHALL fault if any of these hold, evaluated at acceptance:
  - rd_addr[1:0] != 0;
  - word index >= DEPTH;
  - state != READY.
- REQ-025: A faulting response SHALL give rd_fault=1 and rd_data=0.
- REQ-026: A good response SHALL give rd_fault=0 and rd_data=mem[index].
- REQ-027: When rd_valid=0, rd_data SHALL be 0 and rd_fault SHALL be 0.
- REQ-028: Memory contents SHALL persist across ld_start until overwritten; contents are never cleared by reset.
- REQ-029: Responses already in flight when ld_start is sampled SHALL complete with their acceptance-time fault status and data.

Reset
- REQ-030: While reset_n is low, all outputs SHALL be 0, state SHALL be EMPTY and ptr SHALL be 0.
  - Effect is immediate, independent of clk.
  - The read pipeline is flushed.
- REQ-031: reset_n low during LOAD SHALL abort the load; no ld_done pulse and ready=0 after reset.
- REQ-032: Deassertion SHALL take effect on the first rising clk edge after reset_n goes high.

Verification
- REQ-033: Load E3A000AA, E3A01055, E3A020FF with ld_last on the third -> ld_done one pulse, ready=1; read 0x4 -> rd_data=E3A01055, rd_fault=0, RD_LAT cycles later.
- REQ-034: Reads at 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive rd_valid cycles returning E3A000AA, E3A01055, E3A020FF in order; repeat with RD_LAT=2.
- REQ-035: Faulting reads -> rd_valid=1, rd_fault=1, rd_data=0 for each case:
  - read 0x6 (misaligned);
  - read 0x800 with DEPTH=512 (out of range);
  - read 0x0 before any load (not ready).
- REQ-036: Load DEPTH words with ld_last held 0 -> auto-complete at index 511, ld_done pulse; read 0x7FC returns the last word.
- REQ-037: Reset and restart cases:
  - Assert reset_n low after 2 of 3 load words -> ready=0, no ld_done; next read 0x0 faults.
  - ld_start mid-load with ld_valid=1 -> that word is dropped, ptr restarts at 0.

Source files
------------

// File: rtl/imem_loadable.sv
// Loadable instruction memory: a streaming loader fills the array, then a
// fully pipelined read port serves word fetches with per-request fault status.
module imem_loadable #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_fault,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              ld_done,
   output logic              ready
);

   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IDX_W  = ADDR_W - 2;

   typedef enum logic [1:0] {st_empty, st_load, st_ready} state_t;

   state_t              state_reg;
   logic [MEM_AW-1:0]   ptr_reg;
   logic                ld_done_reg;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                wr_en;
   logic                wr_final;
   logic [IDX_W-1:0]    rd_idx;
   logic                rd_fault_next;

   logic [RD_LAT-1:0]   valid_pipe_reg;
   logic [RD_LAT-1:0]   fault_pipe_reg;
   logic [DATA_W-1:0]   data_pipe_reg [RD_LAT];

   // A word offered in the same cycle as ld_start belongs to the aborted load.
   assign ld_ready = (state_reg == st_load) && !ld_start;
   assign wr_en    = ld_ready && ld_valid;
   assign wr_final = wr_en && (ld_last || (ptr_reg == MEM_AW'(DEPTH - 1)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= st_empty;
         ptr_reg     <= '0;
         ld_done_reg <= 1'b0;
      end else begin
         ld_done_reg <= 1'b0;
         case (state_reg)
            st_empty, st_ready: begin
               if (ld_start) begin
                  state_reg <= st_load;
                  ptr_reg   <= '0;
               end
            end
            st_load: begin
               if (ld_start) begin
                  ptr_reg <= '0;
               end else if (wr_en) begin
                  ptr_reg <= ptr_reg + MEM_AW'(1);
                  if (wr_final) begin
                     state_reg   <= st_ready;
                     ld_done_reg <= 1'b1;
                  end
               end
            end
            default: begin
               state_reg <= st_empty;
               ptr_reg   <= '0;
            end
         endcase
      end
   end

   assign rd_idx        = rd_addr[ADDR_W-1:2];
   assign rd_fault_next = (rd_addr[1:0] != 2'b00) ||
                          (rd_idx >= IDX_W'(DEPTH)) ||
                          (state_reg != st_ready);

   // Array and data stages carry no reset so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[ptr_reg] <= ld_data;
      end
      if (rd_req) begin
         data_pipe_reg[0] <= mem[rd_idx[MEM_AW-1:0]];
      end
      for (int i = 1; i < RD_LAT; i++) begin
         data_pipe_reg[i] <= data_pipe_reg[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_pipe_reg <= '0;
         fault_pipe_reg <= '0;
      end else begin
         valid_pipe_reg[0] <= rd_req;
         fault_pipe_reg[0] <= rd_req && rd_fault_next;
         for (int i = 1; i < RD_LAT; i++) begin
            valid_pipe_reg[i] <= valid_pipe_reg[i-1];
            fault_pipe_reg[i] <= fault_pipe_reg[i-1];
         end
      end
   end

   assign rd_valid = valid_pipe_reg[RD_LAT-1];
   assign rd_fault = valid_pipe_reg[RD_LAT-1] && fault_pipe_reg[RD_LAT-1];
   assign rd_data  = (valid_pipe_reg[RD_LAT-1] && !fault_pipe_reg[RD_LAT-1]) ?
                     data_pipe_reg[RD_LAT-1] : '0;
   assign ld_done  = ld_done_reg;
   assign ready    = (state_reg == st_ready);

endmodule
